// File: rtl/excess3_to_bcd_serial.sv
// excess3_to_bcd_serial: serial LSB-first excess-3 to BCD decoder with digit/word packing (optional err_count via EXCESS3_DEC_ERRCNT_EN)
module excess3_to_bcd_serial #(
    parameter int NUM_DIGITS = 2
) (
    input  logic                      clock,
    input  logic                      reset,
    input  logic                      X,
    input  logic                      X_valid,
    output logic                      S,
    output logic                      V,
    output logic [3:0]                digit,
    output logic                      digit_valid,
    output logic                      digit_err,
    output logic [4*NUM_DIGITS-1:0]   word,
    output logic                      word_valid,
    output logic                      word_err
`ifdef EXCESS3_DEC_ERRCNT_EN
    ,
    output logic [7:0]                err_count
`endif
);
    localparam int IW = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;

    logic [1:0]              pos_q, pos_d;
    logic                    b_q, b_d;
    logic [2:0]              res_q, res_d;
    logic [IW-1:0]           idx_q, idx_d;
    logic [4*NUM_DIGITS-1:0] acc_q, acc_d, acc_n;
    logic                    eacc_q, eacc_d;
    logic [3:0]              digit_q, digit_d;
    logic                    digit_valid_q, digit_valid_d;
    logic                    digit_err_q, digit_err_d;
    logic [4*NUM_DIGITS-1:0] word_q, word_d;
    logic                    word_valid_q, word_valid_d;
    logic                    word_err_q, word_err_d;
    logic                    take, s_raw, fb, bad, last, wlast;
    logic [3:0]              res;

    // Serial subtract-3 datapath: result bit and validity flag for the current bit
    always_comb begin
        take  = X_valid & ~reset;
        s_raw = (pos_q == 2'd0) ? ~X : (pos_q == 2'd1) ? (~X ^ b_q) : (X ^ b_q);
        fb    = ~X & b_q;
        res   = {s_raw, res_q};
        bad   = fb | (res > 4'd9);
        last  = take & (pos_q == 2'd3);
        wlast = last & (idx_q == IW'(NUM_DIGITS - 1));
        S     = take & s_raw;
        V     = last & bad;
    end

    // Next-state for bit position, borrow, partial digit, word packing and outputs
    always_comb begin
        pos_d         = take ? pos_q + 2'd1 : pos_q;
        b_d           = ~take ? b_q : (pos_q == 2'd0) ? ~X : (pos_q == 2'd1) ? (~X | b_q) :
                        (pos_q == 2'd2) ? (~X & b_q) : 1'b0;
        res_d[0]      = (take && pos_q == 2'd0) ? s_raw : res_q[0];
        res_d[1]      = (take && pos_q == 2'd1) ? s_raw : res_q[1];
        res_d[2]      = (take && pos_q == 2'd2) ? s_raw : res_q[2];
        acc_n         = acc_q;
        for (int i = 0; i < NUM_DIGITS; i++)
            if (idx_q == IW'(i)) acc_n[4*i +: 4] = res;
        idx_d         = !last ? idx_q : wlast ? '0 : idx_q + 1'b1;
        acc_d         = !last ? acc_q : wlast ? '0 : acc_n;
        eacc_d        = !last ? eacc_q : wlast ? 1'b0 : (eacc_q | bad);
        digit_d       = last ? res : digit_q;
        digit_err_d   = last ? bad : digit_err_q;
        digit_valid_d = last;
        word_d        = wlast ? acc_n : word_q;
        word_err_d    = wlast ? (eacc_q | bad) : word_err_q;
        word_valid_d  = wlast;
    end

    // State and output registers with synchronous reset
    always_ff @(posedge clock) begin
        if (reset) begin
            pos_q         <= '0;
            b_q           <= 1'b0;
            res_q         <= '0;
            idx_q         <= '0;
            acc_q         <= '0;
            eacc_q        <= 1'b0;
            digit_q       <= '0;
            digit_valid_q <= 1'b0;
            digit_err_q   <= 1'b0;
            word_q        <= '0;
            word_valid_q  <= 1'b0;
            word_err_q    <= 1'b0;
        end else begin
            pos_q         <= pos_d;
            b_q           <= b_d;
            res_q         <= res_d;
            idx_q         <= idx_d;
            acc_q         <= acc_d;
            eacc_q        <= eacc_d;
            digit_q       <= digit_d;
            digit_valid_q <= digit_valid_d;
            digit_err_q   <= digit_err_d;
            word_q        <= word_d;
            word_valid_q  <= word_valid_d;
            word_err_q    <= word_err_d;
        end
    end

    assign digit       = digit_q;
    assign digit_valid = digit_valid_q;
    assign digit_err   = digit_err_q;
    assign word        = word_q;
    assign word_valid  = word_valid_q;
    assign word_err    = word_err_q;

`ifdef EXCESS3_DEC_ERRCNT_EN
    logic [7:0] cnt_q, cnt_d;

    // Saturating count of invalid digits
    always_comb begin
        cnt_d = (last && bad && cnt_q != 8'hFF) ? cnt_q + 8'd1 : cnt_q;
    end

    // Error counter register
    always_ff @(posedge clock) begin
        if (reset) cnt_q <= '0;
        else       cnt_q <= cnt_d;
    end

    assign err_count = cnt_q;
`endif
endmodule

// File: doc/excess3_to_bcd_serial.md
EXCESS3_TO_BCD_SERIAL -- requirements
Module: excess3_to_bcd_serial

Interface
REQ-001 Parameter: NUM_DIGITS, 2, number of decoded digits packed into one output word (range 1..8).
REQ-002 Port: clock  input  1  sole clock; all state updates on its rising edge.
REQ-003 Port: reset  input  1  synchronous, active-high reset, sampled on rising clock edge.
REQ-004 Port: X  input  1  serial excess-3 code bit, LSB first, four bits per digit.
REQ-005 Port: X_valid  input  1  X qualifier; bit consumed only in cycles with X_valid=1.
REQ-006 Port: S  output  1  serial BCD result bit, combinational (Mealy) on current X and state.
REQ-007 Port: V  output  1  combinational invalid-code flag, valid only in the 4th-bit cycle.
REQ-008 Port: digit  output  4  last decoded BCD digit, registered.
REQ-009 Port: digit_valid  output  1  one-cycle pulse: digit and digit_err updated.
REQ-010 Port: digit_err  output  1  registered copy of V for the digit in digit.
REQ-011 Port: word  output  4*NUM_DIGITS  packed digits; first-received digit in bits [3:0].
REQ-012 Port: word_valid  output  1  one-cycle pulse: word and word_err updated.
REQ-013 Port: word_err  output  1  OR of digit_err over all digits of the word.

Function
REQ-014 Block SHALL subtract 0011 from each 4-bit excess-3 code serially, LSB first, emitting result bit on S in the same cycle the code bit is on X.
REQ-015 Bit-position counter (0..3) SHALL advance by one per consumed bit and wrap 3->0; borrow register SHALL clear at wrap.
REQ-016 Per position with borrow b: pos0 S=~X, b<=~X; pos1 S=~X^b, b<=~X|b; pos2 S=X^b, b<=~X&b; pos3 S=X^b, final borrow=~X&b.
REQ-017 In pos3 cycle V SHALL be 1 iff final borrow=1 (code<0011) or result>1001 (code>1100); V=0 at all other times.
REQ-018 When X_valid=0: S=0, V=0, no state changes, no pulses; stalls of any length allowed mid-digit.
REQ-019 Cycle after a consumed pos3 bit: digit<=4-bit result, digit_err<=V, digit_valid=1 for exactly one cycle (latency 1 from last bit).
REQ-020 Invalid digits SHALL still be reported: digit carries raw 4-bit difference modulo 16.
REQ-021 Digit index (0..NUM_DIGITS-1) SHALL increment on each completed digit and wrap; on completing index NUM_DIGITS-1, word and word_err SHALL update and word_valid pulse in the same cycle as digit_valid.
REQ-022 word_err SHALL cover only digits of the current word; accumulator clears after each word_valid.
REQ-023 digit, digit_err, word, word_err SHALL hold between pulses.
REQ-024 Back-to-back digits with X_valid held 1 SHALL be accepted with no idle cycle.

Reset
REQ-025 reset=1 SHALL clear bit counter, borrow, partial result, digit index, word accumulator and error accumulator; takes priority over X_valid.
REQ-026 After reset all registered outputs SHALL be 0 (digit=0, digit_valid=0, digit_err=0, word=0, word_valid=0, word_err=0); S and V SHALL be 0 while reset=1.
REQ-027 Reset mid-digit or mid-word SHALL discard partial data; next consumed bit is pos0 of digit 0.

Configuration
REQ-028 Macro EXCESS3_DEC_ERRCNT_EN defined: extra output err_count (8 bits) SHALL count digits with digit_err=1, saturate at 255, clear on reset.
REQ-029 Macro EXCESS3_DEC_ERRCNT_EN undefined: err_count port and counter SHALL not exist; all other behaviour identical.

Verification
REQ-030 Code 0101 (X=1,0,1,0, X_valid=1) -> S=0,1,0,0; V=0; next cycle digit=0010, digit_valid=1, digit_err=0.
REQ-031 Code 1100 -> S=1,0,0,1; digit=1001, digit_err=0; code 0010 -> V=1 in pos3 cycle, digit_err=1; code 1101 -> V=1, digit_err=1.
REQ-032 NUM_DIGITS=2, codes 0100 then 1011 back-to-back -> word=8'h81, word_valid one pulse coincident with 2nd digit_valid, word_err=0.
REQ-033 Code 0101 with X_valid=0 for 3 cycles between bits 1 and 2 -> S=0/V=0 during stall; result digit=0010, latency unchanged after last bit.
REQ-034 reset asserted after 2 bits of a digit -> all outputs 0; then full code 0110 -> digit=0011, index restarts at 0.
REQ-035 With EXCESS3_DEC_ERRCNT_EN: 300 invalid codes (0000) -> err_count=255; reset -> err_count=0.
